// File: rtl/seg7_counter_n.sv
// seg7_counter_n: DIGITS-digit up/down counter (BCD or hex per digit) driving
// registered active-low seven-segment outputs with optional leading-zero blanking.
// A change of dec_mode forces a one-cycle CLEAR that zeroes the count.
module seg7_counter_n #(
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  dec_mode,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  wrap
);

  typedef enum logic {COUNT = 1'b0, CLEAR = 1'b1} state_t;

  state_t     state_reg;
  logic       mode_reg;
  logic [3:0] digit_reg  [DIGITS];
  logic [3:0] digit_next [DIGITS];
  logic [6:0] seg        [DIGITS];
  logic [DIGITS:0]   ripple;
  logic [DIGITS-1:0] lz;
  logic       mode_change;
  logic       step_en;
  logic [3:0] digit_max;

  // Segment patterns gfedcba, active low; anything unexpected is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg_decode = 7'b1000000;
      4'h1:    seg_decode = 7'b1111001;
      4'h2:    seg_decode = 7'b0100100;
      4'h3:    seg_decode = 7'b0110000;
      4'h4:    seg_decode = 7'b0011001;
      4'h5:    seg_decode = 7'b0010010;
      4'h6:    seg_decode = 7'b0000010;
      4'h7:    seg_decode = 7'b1111000;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0010000;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b0000011;
      4'hC:    seg_decode = 7'b1000110;
      4'hD:    seg_decode = 7'b0100001;
      4'hE:    seg_decode = 7'b0000110;
      4'hF:    seg_decode = 7'b0001110;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // A mode change pre-empts counting; simultaneous up/down cancel out.
  assign mode_change = (dec_mode != mode_reg);
  assign step_en     = (state_reg == COUNT) && !mode_change && (up ^ down);
  assign digit_max   = mode_reg ? 4'd9 : 4'd15;
  assign ripple[0]   = step_en;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic at_end;
      // A digit passes the carry/borrow on when it is about to roll over.
      assign at_end = up ? (digit_reg[gi] == digit_max) : (digit_reg[gi] == 4'd0);
      assign ripple[gi+1] = ripple[gi] & at_end;
      assign digit_next[gi] = !ripple[gi] ? digit_reg[gi] :
                              up ? (at_end ? 4'd0 : digit_reg[gi] + 4'd1) :
                                   (at_end ? digit_max : digit_reg[gi] - 4'd1);

      // lz[k] is set when digit k and every digit above it are zero.
      if (gi == DIGITS - 1) begin : g_top
        assign lz[gi] = (digit_reg[gi] == 4'd0);
      end else begin : g_mid
        assign lz[gi] = lz[gi+1] & (digit_reg[gi] == 4'd0);
      end

      // Digit 0 always shows; higher leading zeros go dark when blanking is on.
      if (gi == 0) begin : g_lsd
        assign seg[gi] = seg_decode(digit_reg[gi]);
      end else begin : g_msd
        assign seg[gi] = (BLANK_LZ && lz[gi]) ? 7'b1111111 : seg_decode(digit_reg[gi]);
      end
    end
  endgenerate

  // Mode FSM, count registers and wrap pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= COUNT;
      mode_reg  <= dec_mode;
      wrap      <= 1'b0;
      for (int k = 0; k < DIGITS; k++) digit_reg[k] <= 4'd0;
    end else begin
      mode_reg <= dec_mode;
      wrap     <= 1'b0;
      if (mode_change) begin
        // Zero right away so a digit never holds A..F once in decimal mode.
        state_reg <= CLEAR;
        for (int k = 0; k < DIGITS; k++) digit_reg[k] <= 4'd0;
      end else if (state_reg == CLEAR) begin
        state_reg <= COUNT;
        for (int k = 0; k < DIGITS; k++) digit_reg[k] <= 4'd0;
      end else begin
        for (int k = 0; k < DIGITS; k++) digit_reg[k] <= digit_next[k];
        wrap <= ripple[DIGITS];
      end
    end
  end

  // Display register: one cycle behind the count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      HEX <= '1;
    end else begin
      for (int k = 0; k < DIGITS; k++) HEX[7*k +: 7] <= seg[k];
    end
  end

endmodule

// File: tb/tb_seg7_counter_n.sv
// Scoreboard bench for seg7_counter_n (DIGITS=4, BLANK_LZ=1).
module tb_seg7_counter_n;
  localparam int D = 4;
  localparam int W = 7 * D;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         up, down, dec_mode;
  logic [W-1:0] HEX;
  logic         wrap;

  typedef struct {
    logic [W-1:0] hex;
    logic         wrap;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cnt_m, mode_m, clr_m, wrap_seen;

  seg7_counter_n #(.DIGITS(D), .BLANK_LZ(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .up(up), .down(down),
    .dec_mode(dec_mode), .HEX(HEX), .wrap(wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
     15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [W-1:0] hex_of(input int value, input int base);
    logic [W-1:0] r;
    int dg [D];
    int v;
    bit seen;
    v = value;
    for (int k = 0; k < D; k++) begin dg[k] = v % base; v = v / base; end
    seen = 0;
    r = '1;
    for (int k = D - 1; k >= 0; k--) begin
      if (dg[k] != 0) seen = 1;
      if (seen || k == 0) r[7*k +: 7] = seg_of(dg[k]);
    end
    return r;
  endfunction

  function automatic int modulus(input int m);
    int r;
    r = 1;
    for (int k = 0; k < D; k++) r = r * (m ? 10 : 16);
    return r;
  endfunction

  // One clock cycle: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic u, input logic d, input logic m, input bit show);
    exp_t e, o;
    int md;
    up = u; down = d; dec_mode = m;
    e.hex  = hex_of(cnt_m, mode_m ? 10 : 16);
    e.wrap = 1'b0;
    md = modulus(mode_m);
    if (m != mode_m[0]) begin
      cnt_m = 0; clr_m = 1;
    end else if (clr_m != 0) begin
      cnt_m = 0; clr_m = 0;
    end else if (u && !d) begin
      if (cnt_m == md - 1) e.wrap = 1'b1;
      cnt_m = (cnt_m + 1) % md;
    end else if (d && !u) begin
      if (cnt_m == 0) e.wrap = 1'b1;
      cnt_m = (cnt_m + md - 1) % md;
    end
    mode_m = m;
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    o = sb.pop_front();
    chk("sb_hex", HEX, o.hex);
    chk("sb_wrap", {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, o.wrap});
    if (wrap) wrap_seen++;
    if (show)
      $display("cycle up=%0b down=%0b mode=%0b hex=%h wrap=%0b model=%0d", u, d, m, HEX, wrap, cnt_m);
  endtask

  task automatic pulses(input int n, input logic dir_up, input logic m);
    for (int i = 0; i < n; i++) begin
      step(dir_up, !dir_up, m, 0);
      step(0, 0, m, 0);
    end
  endtask

  task automatic do_reset(input logic m);
    reset = 1'b1; up = 0; down = 0; dec_mode = m;
    @(posedge CLOCK_50);
    #1;
    chk("rst_hex", HEX, '1);
    chk("rst_wrap", {{(W-1){1'b0}}, wrap}, '0);
    reset = 1'b0;
    cnt_m = 0; clr_m = 0; mode_m = m;
    sb.delete();
  endtask

  initial begin
    // Reset and first display after release.
    do_reset(1);
    step(0, 0, 1, 1);
    chk("first_hex", HEX, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

    // Full decimal wrap: 10000 up pulses.
    wrap_seen = 0;
    pulses(9999, 1, 1);
    chk("no_early_wrap", wrap_seen, 0);
    pulses(1, 1, 1);
    chk("one_wrap", wrap_seen, 1);
    step(0, 0, 1, 1);
    chk("dec_wrap_hex", HEX, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

    // Hex underflow from zero.
    do_reset(0);
    wrap_seen = 0;
    step(0, 1, 0, 1);
    chk("ffff_wrap", wrap_seen, 1);
    step(0, 0, 0, 1);
    chk("ffff_hex", HEX, {4{7'b0001110}});

    // 0019 -> 0020 carry with blanking.
    do_reset(1);
    pulses(19, 1, 1);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("0020_hex", HEX, {7'h7F, 7'h7F, 7'b0100100, 7'b1000000});

    // Both requests high: hold at 0042.
    do_reset(1);
    pulses(42, 1, 1);
    wrap_seen = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
    chk("hold_wrap", wrap_seen, 0);
    chk("0042_hex", HEX, {7'h7F, 7'h7F, 7'b0011001, 7'b0100100});

    // Hex 00AF, switch to decimal with concurrent up pulses.
    do_reset(0);
    pulses(175, 1, 0);
    step(0, 0, 0, 1);
    chk("00af_hex", HEX, {7'h7F, 7'h7F, 7'b0001000, 7'b0001110});
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("clear_hex", HEX, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

    // A few down steps in decimal to check borrow to 9999.
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    chk("9999_hex", HEX, {4{7'b0010000}});

    // Asynchronous reset between edges at 1234.
    do_reset(1);
    pulses(1234, 1, 1);
    step(0, 0, 1, 1);
    chk("1234_hex", HEX, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    #2;
    reset = 1'b1;
    #1;
    chk("async_hex", HEX, '1);
    chk("async_wrap", {{(W-1){1'b0}}, wrap}, '0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    cnt_m = 0; clr_m = 0; mode_m = 1;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);

    // Reset during CLEAR leaves no wrap and a zero count.
    step(0, 0, 0, 1);
    do_reset(0);
    step(0, 0, 0, 1);
    chk("clr_rst_hex", HEX, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
